// File: rtl/rtc_snapshot_reader_pkg.sv
// Shared types and constants for the RTC snapshot reader: FSM states, the
// transfer command and the register read order.
package rtc_snapshot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_STB,
        ST_CMD_GAP,
        ST_ADR_STB,
        ST_ADR_GAP,
        ST_DAT_STB,
        ST_DAT_GAP,
        ST_DONE
    } state_e;

    localparam logic [7:0] CMD_XFER = 8'hF0;
    localparam int         NUM_REGS = 12;
    localparam int         IDX_W    = 4;

    // Read order: time/date, then timer, then running chrono.
    function automatic logic [7:0] reg_addr(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:    reg_addr = 8'h21;
            4'd1:    reg_addr = 8'h22;
            4'd2:    reg_addr = 8'h23;
            4'd3:    reg_addr = 8'h24;
            4'd4:    reg_addr = 8'h25;
            4'd5:    reg_addr = 8'h26;
            4'd6:    reg_addr = 8'h41;
            4'd7:    reg_addr = 8'h42;
            4'd8:    reg_addr = 8'h43;
            4'd9:    reg_addr = 8'h51;
            4'd10:   reg_addr = 8'h52;
            4'd11:   reg_addr = 8'h53;
            default: reg_addr = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/rtc_bus_phase_timer.sv
// Bus phase counter: counts 0..T_PHASE-1 while enabled and flags the last
// cycle of each phase; it restarts from zero on every new phase.
module rtc_bus_phase_timer #(
    parameter int T_PHASE = 4,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && (cnt_q == CNT_W'(T_PHASE - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || tc_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_snapshot_reader.sv
// Reads 12 RTC registers over the multiplexed bus after a freeze command and
// commits them together with a one-cycle hs_flag for the display latch.
module rtc_snapshot_reader
    import rtc_snapshot_pkg::*;
#(
    parameter int T_PHASE = 4,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic       busy,
    output logic       hs_flag,
    output logic [7:0] secondo_o,
    output logic [7:0] minute_o,
    output logic [7:0] ora_o,
    output logic [7:0] giorno_o,
    output logic [7:0] messe_o,
    output logic [7:0] agno_o,
    output logic [7:0] s_oro_o,
    output logic [7:0] m_oro_o,
    output logic [7:0] h_oro_o,
    output logic [7:0] s_run_o,
    output logic [7:0] m_run_o,
    output logic [7:0] h_run_o
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       shadow_q [NUM_REGS];
    logic [7:0]       data_q   [NUM_REGS];
    logic             tc;
    logic             last_idx;
    logic             commit;

    rtc_bus_phase_timer #(
        .T_PHASE (T_PHASE),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .en_i  ((state_q != ST_IDLE) && (state_q != ST_DONE)),
        .tc_o  (tc)
    );

    assign last_idx = (idx_q == IDX_W'(NUM_REGS - 1));
    assign commit   = (state_q == ST_DAT_GAP) && tc && last_idx;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CMD_STB;
                    idx_d   = '0;
                end
            end
            ST_CMD_STB: if (tc) state_d = ST_CMD_GAP;
            ST_CMD_GAP: begin
                if (tc) begin
                    state_d = ST_ADR_STB;
                    idx_d   = '0;
                end
            end
            ST_ADR_STB: if (tc) state_d = ST_ADR_GAP;
            ST_ADR_GAP: if (tc) state_d = ST_DAT_STB;
            ST_DAT_STB: if (tc) state_d = ST_DAT_GAP;
            ST_DAT_GAP: begin
                if (tc) begin
                    if (last_idx) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ADR_STB;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bus pins decode straight from the registered state, so reset idles them at once.
    always_comb begin
        cs_n   = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        a_d    = 1'b0;
        ad_oe  = 1'b0;
        ad_out = 8'h00;
        case (state_q)
            ST_CMD_STB: begin
                cs_n   = 1'b0;
                wr_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = CMD_XFER;
            end
            ST_ADR_STB: begin
                cs_n   = 1'b0;
                wr_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = reg_addr(idx_q);
            end
            ST_DAT_STB: begin
                cs_n = 1'b0;
                rd_n = 1'b0;
                a_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign hs_flag = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= 8'h00;
                data_q[i]   <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                if ((state_q == ST_DAT_STB) && tc && (idx_q == IDX_W'(i))) begin
                    shadow_q[i] <= ad_in;
                end
                if (commit) begin
                    data_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign secondo_o = data_q[0];
    assign minute_o  = data_q[1];
    assign ora_o     = data_q[2];
    assign giorno_o  = data_q[3];
    assign messe_o   = data_q[4];
    assign agno_o    = data_q[5];
    assign s_oro_o   = data_q[6];
    assign m_oro_o   = data_q[7];
    assign h_oro_o   = data_q[8];
    assign s_run_o   = data_q[9];
    assign m_run_o   = data_q[10];
    assign h_run_o   = data_q[11];

endmodule

// File: tb/tb_rtc_snapshot_reader.sv
// Directed bench: three readers (T_PHASE 4, 1, 7) against an RTC model that
// answers address XOR key, with bus monitors and hand-computed expectations.
module tb_rtc_snapshot_reader;

    localparam int TP [3] = '{4, 1, 7};
    localparam logic [7:0] ADDR_T [12] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                           8'h41, 8'h42, 8'h43, 8'h51, 8'h52, 8'h53};
    localparam logic [7:0] EXP_A5 [12] = '{8'h84, 8'h87, 8'h86, 8'h81, 8'h80, 8'h83,
                                           8'hE4, 8'hE7, 8'hE6, 8'hF4, 8'hF7, 8'hF6};

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a  [3];
    logic [7:0] key;
    logic [7:0] ad_in_a  [3];
    logic [7:0] ad_out_a [3];
    logic       ad_oe_a  [3];
    logic       cs_n_a   [3];
    logic       rd_n_a   [3];
    logic       wr_n_a   [3];
    logic       a_d_a    [3];
    logic       busy_a   [3];
    logic       hs_a     [3];
    logic [7:0] d_a      [3][12];

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // Clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [7:0] addr_q = 8'h00;
        rtc_snapshot_reader #(.T_PHASE(TP[g]), .CNT_W(8)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start_a[g]),
            .ad_in     (ad_in_a[g]),
            .ad_out    (ad_out_a[g]),
            .ad_oe     (ad_oe_a[g]),
            .cs_n      (cs_n_a[g]),
            .rd_n      (rd_n_a[g]),
            .wr_n      (wr_n_a[g]),
            .a_d       (a_d_a[g]),
            .busy      (busy_a[g]),
            .hs_flag   (hs_a[g]),
            .secondo_o (d_a[g][0]),
            .minute_o  (d_a[g][1]),
            .ora_o     (d_a[g][2]),
            .giorno_o  (d_a[g][3]),
            .messe_o   (d_a[g][4]),
            .agno_o    (d_a[g][5]),
            .s_oro_o   (d_a[g][6]),
            .m_oro_o   (d_a[g][7]),
            .h_oro_o   (d_a[g][8]),
            .s_run_o   (d_a[g][9]),
            .m_run_o   (d_a[g][10]),
            .h_run_o   (d_a[g][11])
        );
        // RTC model: latch the written address, answer address XOR key.
        always @(posedge clk) begin
            if (!cs_n_a[g] && !wr_n_a[g] && !a_d_a[g]) addr_q <= ad_out_a[g];
        end
        assign ad_in_a[g] = addr_q ^ key;
    end

    // Bus protocol monitor.
    int         wr_cnt [3] = '{0, 0, 0};
    int         rd_cnt [3] = '{0, 0, 0};
    int         wr_len [3] = '{0, 0, 0};
    int         rd_len [3] = '{0, 0, 0};
    int         len_err[3] = '{0, 0, 0};
    int         viol   [3] = '{0, 0, 0};
    int         hs_cnt [3] = '{0, 0, 0};
    int         hs_at  [3] = '{0, 0, 0};
    logic       prev_wr[3] = '{1'b1, 1'b1, 1'b1};
    logic       prev_rd[3] = '{1'b1, 1'b1, 1'b1};
    logic       prev_busy = 1'b0;
    int         busy_rise = 0;
    int         busy_fall = 0;
    logic       log_en = 1'b0;
    logic [8:0] ev_q [$];
    logic [8:0] exp_q [$];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (wr_n_a[i] === 1'b0) begin
                if (prev_wr[i]) begin
                    wr_cnt[i]++;
                    wr_len[i] = 1;
                    if (i == 0 && log_en) ev_q.push_back({1'b0, ad_out_a[0]});
                end else begin
                    wr_len[i]++;
                end
            end else if (!prev_wr[i] && wr_len[i] != TP[i]) begin
                len_err[i]++;
            end
            if (rd_n_a[i] === 1'b0) begin
                if (prev_rd[i]) begin
                    rd_cnt[i]++;
                    rd_len[i] = 1;
                    if (i == 0 && log_en) ev_q.push_back({1'b1, 8'h00});
                end else begin
                    rd_len[i]++;
                end
            end else if (!prev_rd[i] && rd_len[i] != TP[i]) begin
                len_err[i]++;
            end
            if (ad_oe_a[i] === 1'b1 && rd_n_a[i] === 1'b0) viol[i]++;
            if (cs_n_a[i] === 1'b1 && (rd_n_a[i] === 1'b0 || wr_n_a[i] === 1'b0)) viol[i]++;
            if (hs_a[i] === 1'b1) begin
                hs_cnt[i]++;
                hs_at[i] = cyc;
            end
            prev_wr[i] = (wr_n_a[i] !== 1'b0);
            prev_rd[i] = (rd_n_a[i] !== 1'b0);
        end
        if (busy_a[0] === 1'b1 && !prev_busy) busy_rise = cyc;
        if (busy_a[0] !== 1'b1 && prev_busy) busy_fall = cyc;
        prev_busy = (busy_a[0] === 1'b1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_cnt[0] < target && n < budget) begin
            step();
            n++;
        end
        chk("hs_wait", hs_cnt[0], target);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_cs_n"}, cs_n_a[0], 1);
        chk({tag, "_rd_n"}, rd_n_a[0], 1);
        chk({tag, "_wr_n"}, wr_n_a[0], 1);
        chk({tag, "_ad_oe"}, ad_oe_a[0], 0);
        chk({tag, "_busy"}, busy_a[0], 0);
        chk({tag, "_hs"}, hs_a[0], 0);
        for (int i = 0; i < 12; i++) chk({tag, "_data"}, d_a[0][i], 8'h00);
    endtask

    initial begin
        int k;
        int n;
        int hold_bad;
        int base;
        int hsb;
        logic [8:0] ev;
        logic [8:0] ex;

        reset = 1'b1;
        start_a = '{1'b0, 1'b0, 1'b0};
        key = 8'hA5;
        repeat (4) step();
        reset = 1'b0;
        step();
        chk_idle_zero("rst");
        chk("rst_ad_out", ad_out_a[0], 8'h00);
        chk("rst_a_d", a_d_a[0], 0);

        // Snapshot on all three instances; stray start while busy on instance 0.
        log_en = 1'b1;
        k = cyc + 1;
        start_a = '{1'b1, 1'b1, 1'b1};
        step();
        start_a = '{1'b0, 1'b0, 1'b0};
        while (cyc < k + 49) step();
        start_a[0] = 1'b1;
        step();
        start_a[0] = 1'b0;
        wait_hs(1, 300);
        chk("hs_cycle", hs_at[0], k + 200);
        chk("busy_rise", busy_rise, k);
        step();
        chk("busy_fall", busy_fall, k + 201);
        chk("hs_pulse_end", hs_a[0], 0);
        log_en = 1'b0;
        for (int i = 0; i < 12; i++) chk("data_a5", d_a[0][i], EXP_A5[i]);

        exp_q.push_back({1'b0, 8'hF0});
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back({1'b0, ADDR_T[i]});
            exp_q.push_back({1'b1, 8'h00});
        end
        chk("ev_count", ev_q.size(), exp_q.size());
        while (exp_q.size() > 0 && ev_q.size() > 0) begin
            ev = ev_q.pop_front();
            ex = exp_q.pop_front();
            chk("bus_event", ev, ex);
        end

        while (cyc < k + 400) step();
        chk("hs_once", hs_cnt[0], 1);
        chk("viol_t4", viol[0], 0);
        chk("len_t4", len_err[0], 0);
        for (int i = 1; i < 3; i++) begin
            chk("wr_count", wr_cnt[i], 13);
            chk("rd_count", rd_cnt[i], 12);
            chk("strobe_len", len_err[i], 0);
            chk("bus_viol", viol[i], 0);
            chk("hs_count", hs_cnt[i], 1);
        end

        // Held start: back-to-back snapshots with one IDLE cycle between.
        k = cyc + 1;
        start_a[0] = 1'b1;
        wait_hs(2, 300);
        chk("held_hs_cycle", hs_at[0], k + 200);
        n = 0;
        while (cs_n_a[0] && n < 10) begin
            step();
            n++;
        end
        chk("retrigger_cycle", cyc, k + 202);
        start_a[0] = 1'b0;
        key = 8'h3C;
        hold_bad = 0;
        n = 0;
        while (!hs_a[0] && n < 300) begin
            for (int i = 0; i < 12; i++) if (d_a[0][i] !== EXP_A5[i]) hold_bad++;
            step();
            n++;
        end
        chk("hold_old", hold_bad, 0);
        chk("hs2_seen", hs_a[0], 1);
        for (int i = 0; i < 12; i++) chk("data_3c", d_a[0][i], ADDR_T[i] ^ 8'h3C);

        // Reset in the DAT_STB of index 5.
        step();
        base = rd_cnt[0];
        hsb = hs_cnt[0];
        start_a[0] = 1'b1;
        step();
        start_a[0] = 1'b0;
        n = 0;
        while (rd_cnt[0] < base + 6 && n < 300) begin
            step();
            n++;
        end
        chk("idx5_reached", rd_cnt[0], base + 6);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle_zero("midrst");
        repeat (5) step();
        chk("no_hs_after_rst", hs_cnt[0], hsb);

        // Fresh snapshot after the abort.
        key = 8'h5A;
        start_a[0] = 1'b1;
        step();
        start_a[0] = 1'b0;
        wait_hs(hsb + 1, 300);
        for (int i = 0; i < 12; i++) chk("data_5a", d_a[0][i], ADDR_T[i] ^ 8'h5A);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rtc_snapshot_reader.md
Name: rtc_snapshot_reader

Overview:
Bus-side producer for the display-latch handshake. On a start request it issues a transfer command to the external RTC over its multiplexed 8-bit address/data bus, then reads 12 time/date/timer registers in a fixed order. It commits all 12 bytes simultaneously and pulses hs_flag for one cycle, so the downstream latch captures a coherent snapshot. It sits between the RTC pad interface and the handshake latch, in the same clock domain as the latch.

Parameters:
T_PHASE, 4, clock cycles per bus phase; legal range 1..255.
CNT_W, 8, width of the phase counter; must hold T_PHASE-1.

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high
start  in  1  snapshot request; sampled only in IDLE
ad_in  in  8  RTC bus read data
ad_out  out  8  RTC bus drive data (address or command)
ad_oe  out  1  1 = drive ad_out onto the pads
cs_n  out  1  RTC chip select, active-low
rd_n  out  1  read strobe, active-low
wr_n  out  1  write strobe, active-low
a_d  out  1  0 = address/command phase, 1 = data phase
busy  out  1  high from start acceptance until the hs_flag cycle, inclusive
hs_flag  out  1  one-cycle pulse; the 12 data outputs are new in this same cycle
secondo_o, minute_o, ora_o, giorno_o, messe_o, agno_o  out  8 each  time/date bytes
s_oro_o, m_oro_o, h_oro_o  out  8 each  timer bytes
s_run_o, m_run_o, h_run_o  out  8 each  running-chrono bytes

Behaviour:
- Reset: every output goes to its value at the next edge: cs_n=rd_n=wr_n=1, ad_oe=0, a_d=0, ad_out=0, busy=0, hs_flag=0, all 12 data bytes =8'h00. State goes to IDLE, index=0, phase counter=0. This applies mid-transaction: the bus is released immediately, with no completion pulse, and the shadow bytes are discarded.
- Bus idle level, held in IDLE and all GAP phases: cs_n=rd_n=wr_n=1, ad_oe=0.
- States: IDLE, CMD_STB, CMD_GAP, ADR_STB, ADR_GAP, DAT_STB, DAT_GAP, DONE.
- Every state except IDLE and DONE lasts exactly T_PHASE cycles. The phase counter counts 0..T_PHASE-1 and the state advances when it reaches T_PHASE-1.
- IDLE: start=1 at edge k moves to CMD_STB and sets busy=1 from cycle k+1.
- CMD_STB: cs_n=0, wr_n=0, a_d=0, ad_oe=1, ad_out=CMD_XFER (8'hF0). This is an address-only write that freezes the RTC's user registers.
- CMD_GAP: bus idle, then ADR_STB with index=0.
- ADR_STB: cs_n=0, wr_n=0, a_d=0, ad_oe=1, ad_out=REG_ADDR[index].
- ADR_GAP: bus idle.
- DAT_STB: cs_n=0, rd_n=0, a_d=1, ad_oe=0. ad_in is captured into shadow[index] on the edge that ends the phase (counter = T_PHASE-1).
- DAT_GAP: bus idle. At the end of the phase, if index<11, increment index and go to ADR_STB; otherwise go to DONE.
- DONE lasts one cycle with hs_flag=1 and busy=1. At the edge entering DONE, all 12 outputs load from the shadow registers together. The next state is IDLE with busy=0 and hs_flag=0.
- Outputs hold between snapshots; they never change except on DONE entry or reset.
- Latency: with start accepted at edge k, hs_flag is high in cycle k+50*T_PHASE+1 (201 cycles for T_PHASE=4).
- start while busy is ignored, not queued. start high in the DONE cycle is ignored. start held high continuously re-triggers in IDLE, giving back-to-back snapshots with exactly one IDLE cycle between them.
- ad_oe and rd_n are never low in the same cycle. No strobe is asserted while cs_n=1.

Decomposition:
- Package rtc_snapshot_pkg:
  - state enum.
  - CMD_XFER=8'hF0.
  - NUM_REGS=12.
  - REG_ADDR table, index->address: 0 secondo 8'h21, 1 minute 8'h22, 2 ora 8'h23, 3 giorno 8'h24, 4 messe 8'h25, 5 agno 8'h26, 6 s_oro 8'h41, 7 m_oro 8'h42, 8 h_oro 8'h43, 9 s_run 8'h51, 10 m_run 8'h52, 11 h_run 8'h53.
- One sub-module, rtc_bus_phase_timer: the phase counter with a terminal-count output, parameterised by T_PHASE. The FSM, shadow bank and output commit stay in the top module.

Test Plan:
- Reset then idle: outputs all 0, cs_n=1, busy=0. start pulse at edge k -> hs_flag single pulse in cycle k+201 (T_PHASE=4); busy high for cycles k+1..k+201.
- RTC model returns address XOR 8'hA5 on reads -> secondo_o=8'h84, agno_o=8'h83, h_run_o=8'hF6. Observed address sequence is F0 (write, no data phase), then 21..26, 41..43, 51..53.
- Bus protocol monitor across a full snapshot with T_PHASE=1 and T_PHASE=7 -> each strobe lasts exactly T_PHASE cycles, no ad_oe/rd_n overlap, no strobe while cs_n=1, exactly 13 wr_n and 12 rd_n assertions.
- Pulse start again at cycle k+50 while busy -> ignored; exactly one hs_flag, at cycle k+201. start held high -> next CMD_STB begins cycle k+203.
- Assert reset during DAT_STB of index 5 -> next cycle the bus is idle, busy=0, outputs 8'h00, no hs_flag. A fresh start then completes normally with correct data.
- Change the RTC model data between two snapshots -> outputs keep the old values until the second hs_flag cycle, then all 12 change in the same cycle.
